mem_access: RTL and testbench

Memory-access pipeline stage that consumes the execute-stage result bundle (destination register, write enable, ALU result) latched in ex_mem and forwards it to mem_wb. Non-memory ops pass through in one cycle. Loads and stores run as byte-serial transactions on the 8-bit unified RAM port. While a transaction is in flight the block stalls the upstream pipeline.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_access_if.sv | 39 +++
 rtl/mem_load_ext.sv | 21 ++
 rtl/mem_access.sv | 183 ++++++++++++++++++
 tb/tb_mem_access.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: op encodings, FSM states and helpers.
package mem_pkg;

  localparam logic [3:0] MemOpNone = 4'b0000;
  localparam logic [3:0] MemOpLb   = 4'b0001;
  localparam logic [3:0] MemOpLh   = 4'b0010;
  localparam logic [3:0] MemOpLw   = 4'b0011;
  localparam logic [3:0] MemOpLbu  = 4'b0101;
  localparam logic [3:0] MemOpLhu  = 4'b0110;
  localparam logic [3:0] MemOpSb   = 4'b1001;
  localparam logic [3:0] MemOpSh   = 4'b1010;
  localparam logic [3:0] MemOpSw   = 4'b1011;

  // Cycles from driving a RAM address to its data appearing on mem_din_i.
  localparam int unsigned RamRdLatency = 1;

  typedef enum logic [1:0] {StIdle, StLoad, StLoadTail, StStore} state_e;

  function automatic logic [2:0] byte_count(logic [3:0] op);
    case (op[1:0])
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic is_load(logic [3:0] op);
    return op inside {MemOpLb, MemOpLh, MemOpLw, MemOpLbu, MemOpLhu};
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return op inside {MemOpSb, MemOpSh, MemOpSw};
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Bundle of ex_mem inputs, mem_wb outputs and the byte-wide RAM port.
// MEM_STALL_CNT_EN adds the perf_stall_o stall-cycle counter output.
interface mem_access_if;
  logic        valid_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  memop_i;
  logic [31:0] maddr_i;
  logic [31:0] sdata_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic        stall_req_o;
  logic        valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] perf_stall_o;
`endif

  modport slave (
`ifdef MEM_STALL_CNT_EN
    output perf_stall_o,
`endif
    input  valid_i, wd_i, wreg_i, wdata_i, memop_i, maddr_i, sdata_i, mem_din_i,
    output mem_a_o, mem_dout_o, mem_wr_o, stall_req_o, valid_o, wd_o, wreg_o, wdata_o
  );

  modport master (
`ifdef MEM_STALL_CNT_EN
    input  perf_stall_o,
`endif
    output valid_i, wd_i, wreg_i, wdata_i, memop_i, maddr_i, sdata_i, mem_din_i,
    input  mem_a_o, mem_dout_o, mem_wr_o, stall_req_o, valid_o, wd_o, wreg_o, wdata_o
  );
endinterface

// File: rtl/mem_load_ext.sv
// Sign/zero extension of an assembled little-endian load word according to memop.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [3:0]  memop,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = word;
    case (memop)
      MemOpLb:  result = {{24{word[7]}}, word[7:0]};
      MemOpLh:  result = {{16{word[15]}}, word[15:0]};
      MemOpLbu: result = {24'd0, word[7:0]};
      MemOpLhu: result = {16'd0, word[15:0]};
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results through, runs loads/stores byte-serially on the RAM.
// MEM_STALL_CNT_EN adds a 32-bit counter of stall_req_o cycles on perf_stall_o.
module mem_access
  import mem_pkg::*;
(
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  wd_q, wd_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] a_q, a_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic [4:0]  wdo_q, wdo_d;
  logic        wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;

  logic        stall;
  logic        mem_wr;
  logic        last;
  logic [1:0]  last_k;
  logic [1:0]  cap_k;
  logic [1:0]  next_k;
  logic [31:0] asm_full;
  logic [31:0] ext_word;

  assign last_k = 2'(byte_count(op_q) - 3'd1);
  assign last   = (k_q == last_k);
  assign next_k = k_q + 2'd1;
  // Data returning now belongs to the address issued RamRdLatency cycles ago.
  assign cap_k  = k_q - 2'(RamRdLatency);

  // Final byte arrives in LOAD_TAIL; merge it before extension.
  always_comb begin
    asm_full = asm_q;
    asm_full[{k_q, 3'b000} +: 8] = bus.mem_din_i;
  end

  mem_load_ext u_load_ext (
    .memop  (op_q),
    .word   (asm_full),
    .result (ext_word)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    op_d    = op_q;
    wd_d    = wd_q;
    sdata_d = sdata_q;
    asm_d   = asm_q;
    a_d     = a_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    wdo_d   = 5'd0;
    wreg_d  = 1'b0;
    wdata_d = wdata_q;
    stall   = 1'b0;
    mem_wr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.valid_i) begin
          if (is_load(bus.memop_i)) begin
            stall   = 1'b1;
            op_d    = bus.memop_i;
            wd_d    = bus.wd_i;
            a_d     = bus.maddr_i;
            asm_d   = 32'd0;
            k_d     = 2'd0;
            state_d = StLoad;
          end else if (is_store(bus.memop_i)) begin
            stall   = 1'b1;
            op_d    = bus.memop_i;
            sdata_d = bus.sdata_i;
            a_d     = bus.maddr_i;
            dout_d  = bus.sdata_i[7:0];
            k_d     = 2'd0;
            state_d = StStore;
          end else begin
            valid_d = 1'b1;
            wdo_d   = bus.wd_i;
            wreg_d  = bus.wreg_i;
            wdata_d = bus.wdata_i;
          end
        end
      end
      StLoad: begin
        stall = 1'b1;
        if (k_q != 2'd0) asm_d[{cap_k, 3'b000} +: 8] = bus.mem_din_i;
        if (last) begin
          state_d = StLoadTail;
        end else begin
          k_d = next_k;
          a_d = a_q + 32'd1;
        end
      end
      StLoadTail: begin
        valid_d = 1'b1;
        wreg_d  = 1'b1;
        wdo_d   = wd_q;
        wdata_d = ext_word;
        k_d     = 2'd0;
        state_d = StIdle;
      end
      StStore: begin
        mem_wr = 1'b1;
        if (last) begin
          valid_d = 1'b1;
          k_d     = 2'd0;
          state_d = StIdle;
        end else begin
          stall  = 1'b1;
          k_d    = next_k;
          a_d    = a_q + 32'd1;
          dout_d = sdata_q[{next_k, 3'b000} +: 8];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      op_q    <= MemOpNone;
      wd_q    <= 5'd0;
      sdata_q <= 32'd0;
      asm_q   <= 32'd0;
      a_q     <= 32'd0;
      dout_q  <= 8'd0;
      valid_q <= 1'b0;
      wdo_q   <= 5'd0;
      wreg_q  <= 1'b0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_q    <= op_d;
      wd_q    <= wd_d;
      sdata_q <= sdata_d;
      asm_q   <= asm_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wdo_q   <= wdo_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  // Gate the strobe during reset so an aborted store issues no further writes.
  assign bus.mem_wr_o    = mem_wr & ~rst;
  assign bus.mem_a_o     = a_q;
  assign bus.mem_dout_o  = dout_q;
  assign bus.stall_req_o = stall;
  assign bus.valid_o     = valid_q;
  assign bus.wd_o        = wdo_q;
  assign bus.wreg_o      = wreg_q;
  assign bus.wdata_o     = wdata_q;

`ifdef MEM_STALL_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 32'd0;
    end else if (stall) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_stall_o = perf_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: byte RAM model, expected results/accesses queued per op.
module tb_mem_access;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  wd;
    logic        wreg;
    logic        chk_data;
    logic [31:0] wdata;
  } res_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] a;
    logic [7:0]  d;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  bit [7:0] ram   [bit [31:0]];
  bit [7:0] model [bit [31:0]];

  res_t res_q[$];
  acc_t wr_q[$];
  acc_t rd_q[$];
  res_t mon_r;
  acc_t mon_a;

  logic [31:0] exp_perf = 32'd0;

  mem_access_if bus ();

  mem_access dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.mem_wr_o) ram[bus.mem_a_o] = bus.mem_dout_o;
    bus.mem_din_i <= ram[bus.mem_a_o];
  end

  always @(posedge clk) begin
    if (rst) exp_perf <= 32'd0;
    else if (bus.stall_req_o) exp_perf <= exp_perf + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(logic [3:0] op);
    case (op[1:0])
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(logic [3:0] op, logic [31:0] a);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < nbytes(op); k++) w[8*k +: 8] = model[a + 32'(k)];
    case (op)
      4'b0001: return {{24{w[7]}}, w[7:0]};
      4'b0010: return {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic set_byte(input logic [31:0] a, input logic [7:0] d);
    ram[a]   = d;
    model[a] = d;
  endtask

  // Monitor: results, write strobes and read addresses against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_o) begin
        if (res_q.size() == 0) begin
          check("spurious_valid", {31'd0, bus.valid_o}, 32'd0);
        end else begin
          mon_r = res_q.pop_front();
          check("res_cycle", cyc, mon_r.cyc);
          check("res_wd", {27'd0, bus.wd_o}, {27'd0, mon_r.wd});
          check("res_wreg", {31'd0, bus.wreg_o}, {31'd0, mon_r.wreg});
          if (mon_r.chk_data) check("res_wdata", bus.wdata_o, mon_r.wdata);
        end
      end
      if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        check("missed_wr", cyc, wr_q[0].cyc);
        void'(wr_q.pop_front());
      end
      if (bus.mem_wr_o) begin
        if (wr_q.size() == 0 || wr_q[0].cyc != cyc) begin
          check("spurious_wr", {31'd0, bus.mem_wr_o}, 32'd0);
        end else begin
          mon_a = wr_q.pop_front();
          check("wr_addr", bus.mem_a_o, mon_a.a);
          check("wr_data", {24'd0, bus.mem_dout_o}, {24'd0, mon_a.d});
        end
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        mon_a = rd_q.pop_front();
        check("rd_addr", bus.mem_a_o, mon_a.a);
        check("rd_nowr", {31'd0, bus.mem_wr_o}, 32'd0);
      end
    end
  end

  // Present one op as ex_mem would: held while stall_req_o is high.
  task automatic do_op(input logic v, input logic [3:0] op, input logic [4:0] wd,
                       input logic wreg, input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] sdata);
    int unsigned c0;
    int n;
    int stall_len;
    res_t r;
    acc_t a;
    @(posedge clk);
    #1;
    bus.valid_i = v;
    bus.memop_i = op;
    bus.wd_i    = wd;
    bus.wreg_i  = wreg;
    bus.wdata_i = wdata;
    bus.maddr_i = addr;
    bus.sdata_i = sdata;
    c0 = cyc;
    n  = nbytes(op);
    stall_len = 0;
    if (v && op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110}) begin
      for (int k = 0; k < n; k++) begin
        a = '{cyc: c0 + 1 + k, a: addr + 32'(k), d: 8'd0};
        rd_q.push_back(a);
      end
      r = '{cyc: c0 + n + 2, wd: wd, wreg: 1'b1, chk_data: 1'b1, wdata: load_val(op, addr)};
      res_q.push_back(r);
      stall_len = n + 1;
    end else if (v && op inside {4'b1001, 4'b1010, 4'b1011}) begin
      for (int k = 0; k < n; k++) begin
        a = '{cyc: c0 + 1 + k, a: addr + 32'(k), d: sdata[8*k +: 8]};
        wr_q.push_back(a);
        model[addr + 32'(k)] = sdata[8*k +: 8];
      end
      r = '{cyc: c0 + n + 1, wd: 5'd0, wreg: 1'b0, chk_data: 1'b0, wdata: 32'd0};
      res_q.push_back(r);
      stall_len = n;
    end else if (v) begin
      r = '{cyc: c0 + 1, wd: wd, wreg: wreg, chk_data: 1'b1, wdata: wdata};
      res_q.push_back(r);
    end
    for (int i = 0; i <= stall_len; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      check("stall", {31'd0, bus.stall_req_o}, (i < stall_len) ? 32'd1 : 32'd0);
    end
    if (!v) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bubble_valid", {31'd0, bus.valid_o}, 32'd0);
      check("bubble_wd", {27'd0, bus.wd_o}, 32'd0);
      check("bubble_wreg", {31'd0, bus.wreg_o}, 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
    check({tag, "_wd"}, {27'd0, bus.wd_o}, 32'd0);
    check({tag, "_wreg"}, {31'd0, bus.wreg_o}, 32'd0);
    check({tag, "_wdata"}, bus.wdata_o, 32'd0);
    check({tag, "_addr"}, bus.mem_a_o, 32'd0);
    check({tag, "_dout"}, {24'd0, bus.mem_dout_o}, 32'd0);
    check({tag, "_wr"}, {31'd0, bus.mem_wr_o}, 32'd0);
    check({tag, "_stall"}, {31'd0, bus.stall_req_o}, 32'd0);
`ifdef MEM_STALL_CNT_EN
    check({tag, "_perf"}, bus.perf_stall_o, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ops [9];
    logic [3:0] op;
    acc_t a;
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1011};
    bus.valid_i = 1'b0;
    bus.memop_i = 4'd0;
    bus.wd_i    = 5'd0;
    bus.wreg_i  = 1'b0;
    bus.wdata_i = 32'd0;
    bus.maddr_i = 32'd0;
    bus.sdata_i = 32'd0;
    set_byte(32'h0000_0100, 8'h80);
    set_byte(32'h0000_0101, 8'h34);
    set_byte(32'h0000_0102, 8'h92);
    set_byte(32'hFFFF_FFFE, 8'h11);
    set_byte(32'hFFFF_FFFF, 8'h22);
    set_byte(32'h0000_0000, 8'h33);
    set_byte(32'h0000_0001, 8'h44);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    do_op(1'b1, 4'b0000, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0);        // ADD pass-through
    do_op(1'b0, 4'b0011, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'h100, 32'h0);      // bubble
    do_op(1'b1, 4'b0001, 5'd3, 1'b0, 32'h0, 32'h100, 32'h0);              // LB
    do_op(1'b1, 4'b0101, 5'd4, 1'b0, 32'h0, 32'h100, 32'h0);              // LBU
    do_op(1'b1, 4'b0010, 5'd6, 1'b0, 32'h0, 32'h101, 32'h0);              // LH misaligned
    do_op(1'b1, 4'b0110, 5'd8, 1'b0, 32'h0, 32'h101, 32'h0);              // LHU
    do_op(1'b1, 4'b1011, 5'd9, 1'b1, 32'h0, 32'h203, 32'hA1B2_C3D4);      // SW
    do_op(1'b1, 4'b0011, 5'd10, 1'b0, 32'h0, 32'h203, 32'h0);             // LW readback
    do_op(1'b1, 4'b0011, 5'd11, 1'b0, 32'h0, 32'hFFFF_FFFE, 32'h0);       // LW wrap
    do_op(1'b1, 4'b1001, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0077); // SB at top
    do_op(1'b1, 4'b1010, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0000_BEEF); // SH wraps
    do_op(1'b1, 4'b0011, 5'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0);        // LW wd=0
    do_op(1'b1, 4'b0000, 5'd31, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h0);       // wreg=0 pass

    for (int i = 0; i < 20; i++) begin
      op = ops[$urandom_range(0, 8)];
      do_op(1'b1, op, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
            32'h400 + 32'($urandom_range(0, 31)), $urandom);
    end

    // Reset in cycle 2 of a word store: only the first byte may be written.
    @(posedge clk);
    #1;
    bus.valid_i = 1'b1;
    bus.memop_i = 4'b1011;
    bus.maddr_i = 32'h300;
    bus.sdata_i = 32'h5566_7788;
    a = '{cyc: cyc + 1, a: 32'h300, d: 8'h88};
    wr_q.push_back(a);
    model[32'h300] = 8'h88;
    @(negedge clk);
    check("rst_stall0", {31'd0, bus.stall_req_o}, 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    @(negedge clk);
    check("rst_wr_gate", {31'd0, bus.mem_wr_o}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("abort");
    do_op(1'b1, 4'b0011, 5'd12, 1'b0, 32'h0, 32'h300, 32'h0);             // readback 0x88

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("res_pending", res_q.size(), 32'd0);
    check("wr_pending", wr_q.size(), 32'd0);
    check("rd_pending", rd_q.size(), 32'd0);
`ifdef MEM_STALL_CNT_EN
    check("perf_final", bus.perf_stall_o, exp_perf);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
